// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO, circular buffer of DEPTH entries with occupancy flags and sticky error flags.
// Latency: FWFT=1 shows the head word combinationally; FWFT=0 presents a popped word one cycle after rden.
// Backpressure: a write is dropped when full (unless a read is accepted in the same cycle) and sets overflow.
module sync_fifo_v2 #(
  parameter int DEPTH         = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wren,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic                         rden,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         o_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr_nxt;
  logic [PW-1:0]         rd_ptr_nxt;
  logic                  rd_acc;
  logic                  wr_acc;

  // Accept decisions come from registered state; flush blocks both requests.
  always_comb begin
    rd_acc = !flush && rden && !empty;
    wr_acc = !flush && wren && (!full || rd_acc);
  end

  // Pointer increment with explicit wrap, so non-power-of-two depths work.
  always_comb begin
    wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
  end

  // Pointers, occupancy and sticky error flags; flush behaves like a soft reset of this state.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr_nxt;
      if (rd_acc) rd_ptr <= rd_ptr_nxt;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wren && !wr_acc) overflow  <= 1'b1;
      if (rden && !rd_acc) underflow <= 1'b1;
    end
  end

  // Storage is never cleared; writes are simply ignored while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wr_ptr] <= i_data;
  end

  // Occupancy flags decode straight from the registered count.
  always_comb begin
    full         = (count == CW'(DEPTH));
    empty        = (count == '0);
    almost_full  = (count >= CW'(AFULL_THRESH));
    almost_empty = (count <= CW'(AEMPTY_THRESH));
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; zero whenever the FIFO is empty.
      always_comb begin
        o_valid = !empty;
        o_data  = empty ? '0 : mem[rd_ptr];
      end
    end else begin : g_reg
      // Registered read: one-cycle valid strobe per accepted pop, data holds otherwise.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          o_data  <= '0;
          o_valid <= 1'b0;
        end else if (flush) begin
          o_valid <= 1'b0;
        end else begin
          o_valid <= rd_acc;
          if (rd_acc) o_data <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: doc/sync_fifo_v2.md
Name: sync_fifo_v2

Overview:
Parametrised synchronous FIFO. Circular buffer with read and write pointers, an occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow flags, and a synchronous flush. A mode parameter selects between two read styles: first-word-fall-through, or registered read with a one-cycle latency and a valid strobe. It is the general-purpose buffer between producer and consumer blocks in the single clock domain.

Parameters:
- DEPTH, 8: number of entries. Any integer ≥ 2; a power of two is not required.
- DATA_WIDTH, 8: width of each entry in bits.
- AFULL_THRESH, DEPTH-2: almost_full asserts when count ≥ this value. Legal range 1..DEPTH.
- AEMPTY_THRESH, 2: almost_empty asserts when count ≤ this value. Legal range 0..DEPTH-1.
- FWFT, 0: read mode. 1 = first-word-fall-through. 0 = registered read.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous empty request.
- wren  in  1  write request.
- i_data  in  DATA_WIDTH  write data.
- rden  in  1  read (pop) request.
- o_data  out  DATA_WIDTH  read data.
- o_valid  out  1  read data valid.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AFULL_THRESH.
- almost_empty  out  1  count ≤ AEMPTY_THRESH.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset, applied when rst_n is low at a clk edge:
  - wr_ptr, rd_ptr and count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0, o_data = 0, o_valid = 0.
  - Storage array is not cleared.
  - Reset mid-operation discards all contents. The first write after reset lands in entry 0.
- Accept rules, evaluated from registered state:
  - rd_acc = rden && !empty.
  - wr_acc = wren && (!full || rd_acc).
  - When full, a simultaneous read and write are both accepted and count is unchanged.
  - When empty, a simultaneous read and write accept the write only. In FWFT=1 the written word becomes visible next cycle.
- Pointers:
  - On wr_acc: mem[wr_ptr] ← i_data, and wr_ptr advances.
  - On rd_acc: rd_ptr advances.
  - Each pointer wraps from DEPTH-1 to 0 with an explicit compare, not modulo 2^n.
- count: next = count + wr_acc − rd_acc. It never exceeds DEPTH and never goes below 0.
- Flags:
  - full, empty, almost_full and almost_empty are decoded combinationally from the registered count.
  - They reflect an operation the cycle after its accepting edge.
- Error flags:
  - overflow is set at the edge where wren=1 and wr_acc=0.
  - underflow is set at the edge where rden=1 and rd_acc=0.
  - Both hold until flush or reset.
- flush:
  - Takes priority over wren and rden in the same cycle; neither request is accepted.
  - Zeroes wr_ptr, rd_ptr and count, and clears overflow, underflow and o_valid.
  - o_data: in FWFT=1 it reads 0 once count is 0; in FWFT=0 it holds its last value.
- FWFT=1 read path:
  - o_valid = !empty.
  - o_data = mem[rd_ptr] when !empty, else 0. Combinational from registered state, zero latency.
  - Asserting rden pops the word currently shown.
- FWFT=0 read path:
  - On rd_acc, o_data ← mem[rd_ptr] at that edge, so data is valid in the following cycle.
  - o_valid is 1 for exactly one cycle per accepted read.
  - o_data holds its value when no read is accepted.
  - Back-to-back reads give consecutive words with o_valid held high.
- Ordering: strict FIFO order across any number of pointer wraps.

Test Plan:
1. DEPTH=8, FWFT=0. Write 0x01..0x08 with wren held 8 cycles → full=1, count=8, almost_full=1 from count=6. Then read 8 cycles → o_data 0x01..0x08 with one-cycle latency, o_valid high for 8 cycles, empty=1 after the last read.
2. Full FIFO, wren=1 for one cycle with rden=0 → overflow=1, count stays 8, contents unchanged. Then wren=1 and rden=1 together → both accepted, count=8, head advances. Then flush → count=0, overflow=0, empty=1.
3. Empty FIFO, rden=1 → underflow=1, o_valid stays 0. Then wren=1 and rden=1 together with i_data=0xAA → write accepted, read rejected, count=1.
4. FWFT=1. Write 0x5A → next cycle o_valid=1 and o_data=0x5A with no rden. rden=1 → empty=1 and o_data=0 next cycle.
5. Wrap test: DEPTH=5, stream 23 words with interleaved reads and writes keeping count between 1 and 4 → output sequence matches input exactly; almost_empty toggles at count ≤ 2.
6. Reset mid-stream: count=3, rst_n=0 for one edge → all outputs at reset values. Write 0x77 then read → 0x77 is returned and no stale data appears.
